onehot_stream_decoder: RTL and testbench

- Decoder counterpart to the team's 4-to-2 casez priority encoder.
- Accepts a stream of binary indices over a valid/ready handshake and emits the matching one-hot vector, also over valid/ready.
- Contains a 2-entry skid buffer, so it sits between an encoder stage and a consumer that may stall.
- Flags out-of-range indices and keeps a saturating error count; the count never wraps.

---
 rtl/onehot_stream_decoder.sv | 135 +++++++++++++
 tb/tb_onehot_stream_decoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_stream_decoder.sv
// Binary-index to one-hot stream decoder with a 2-entry skid buffer and saturating error count.
// Optional input parity check is enabled with `define ONEHOT_DEC_PARITY_EN.
module onehot_stream_decoder #(
    parameter int IDX_W = 2,
    parameter int OUT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
`ifdef ONEHOT_DEC_PARITY_EN
    input  logic             in_par,
    output logic             out_par_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

`ifdef ONEHOT_DEC_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = OUT_W + 1 + PAR_W;
    localparam logic [IDX_W:0] OUT_LIM = (IDX_W + 1)'(OUT_W);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [WORD_W-1:0]   head_q, head_d;
    logic [WORD_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                in_range;
    logic [OUT_W-1:0]    dec_onehot;
    logic [WORD_W-1:0]   new_word;
    logic                in_fire;
    logic                out_fire;

    // Decode the incoming index into the word that is stored in the buffer.
    always_comb begin
        in_range   = ({1'b0, in_idx} < OUT_LIM);
        dec_onehot = in_range ? (OUT_W'(1) << in_idx) : '0;
`ifdef ONEHOT_DEC_PARITY_EN
        if (in_par != (^in_idx)) begin
            new_word = {1'b1, !in_range, {OUT_W{1'b0}}};
        end else begin
            new_word = {1'b0, !in_range, dec_onehot};
        end
`else
        new_word = {!in_range, dec_onehot};
`endif
    end

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        skid_d    = skid_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    head_d  = new_word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_d = new_word;
                end else if (in_fire) begin
                    skid_d  = new_word;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Counted at acceptance; sticks at all-ones instead of wrapping.
        if (in_fire && !in_range && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_onehot = head_q[OUT_W-1:0];
    assign out_err    = head_q[OUT_W];
    assign err_cnt    = err_cnt_q;
`ifdef ONEHOT_DEC_PARITY_EN
    assign out_par_err = head_q[OUT_W+1];
`endif

endmodule

// File: tb/tb_onehot_stream_decoder.sv
// Self-checking bench for onehot_stream_decoder: directed scenarios plus a randomized
// stream compared against a queue-based model of the two-word buffer.
module tb_onehot_stream_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_err;
    logic [1:0] in_idx;
    logic [3:0] out_onehot;
    logic [7:0] err_cnt;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, out_err3;
    logic [1:0] in_idx3;
    logic [2:0] out_onehot3;
    logic [7:0] err_cnt3;

    logic       par_flip;
`ifdef ONEHOT_DEC_PARITY_EN
    logic       in_par, in_par3, out_par_err, out_par_err3;
    assign in_par  = (^in_idx) ^ par_flip;
    assign in_par3 = ^in_idx3;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [3:0] oh;
        logic       err;
        logic       perr;
    } exp_t;

    exp_t mq[$];
    bit   m_rdy;

    onehot_stream_decoder #(.IDX_W(2), .OUT_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
`ifdef ONEHOT_DEC_PARITY_EN
        .in_par     (in_par),
        .out_par_err(out_par_err),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    onehot_stream_decoder #(.IDX_W(2), .OUT_W(3), .CNT_W(8)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_idx     (in_idx3),
`ifdef ONEHOT_DEC_PARITY_EN
        .in_par     (in_par3),
        .out_par_err(out_par_err3),
`endif
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .out_onehot (out_onehot3),
        .out_err    (out_err3),
        .err_cnt    (err_cnt3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle on the OUT_W=4 instance and advances the model across the edge.
    task automatic tick(input logic v, input logic [1:0] idx, input logic ordy);
        bit   in_fire, out_fire;
        exp_t w;
        in_valid  = v;
        in_idx    = idx;
        out_ready = ordy;
        in_fire   = v && m_rdy;
        out_fire  = ordy && (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rdy = 1'b0;
        end else begin
            if (out_fire) void'(mq.pop_front());
            if (in_fire) begin
                w.perr = par_flip;
                w.err  = (int'(idx) >= 4);
                w.oh   = (w.err || w.perr) ? 4'd0 : 4'(2 ** int'(idx));
                mq.push_back(w);
            end
            m_rdy = (mq.size() < 2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        checks += 6;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_onehot !== 4'd0) begin errors++; $display("FAIL reset_onehot: got %b want 0000", out_onehot); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", out_err); end
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        if (in_ready3 !== 1'b0) begin errors++; $display("FAIL reset_in_ready3: got %b want 0", in_ready3); end
        tick(1'b0, 2'd0, 1'b1);
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        if (in_ready3 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready3: got %b want 1", in_ready3); end
    endtask

    task automatic test_single();
        tick(1'b1, 2'd2, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (out_onehot !== 4'b0100) begin errors++; $display("FAIL single_onehot: got %b want 0100", out_onehot); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", out_err); end
        tick(1'b0, 2'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 2'(i), 1'b1);
            want = 4'(2 ** i);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            if (out_onehot !== want) begin errors++; $display("FAIL b2b_onehot[%0d]: got %b want %b", i, out_onehot, want); end
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
        tick(1'b0, 2'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        tick(1'b1, 2'd1, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_one: got %b want 1", in_ready); end
        tick(1'b1, 2'd3, 1'b0);
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_full: got %b want 0", in_ready); end
        if (out_onehot !== 4'b0010) begin errors++; $display("FAIL stall_head: got %b want 0010", out_onehot); end
        // Offered but refused: must not overwrite either slot.
        tick(1'b1, 2'd0, 1'b0);
        checks += 2;
        if (out_onehot !== 4'b0010) begin errors++; $display("FAIL stall_hold: got %b want 0010", out_onehot); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_hold: got %b want 0", in_ready); end
        tick(1'b0, 2'd0, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_second_valid: got %b want 1", out_valid); end
        if (out_onehot !== 4'b1000) begin errors++; $display("FAIL stall_second: got %b want 1000", out_onehot); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_reopen: got %b want 1", in_ready); end
        tick(1'b0, 2'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_saturate();
        int want;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_valid3  = 1'b1;
            in_idx3    = 2'd3;
            out_ready3 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            want = (k + 1 > 255) ? 255 : k + 1;
            checks += 4;
            if (out_valid3 !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d]: got %b want 1", k, out_valid3); end
            if (out_onehot3 !== 3'b000) begin errors++; $display("FAIL sat_onehot[%0d]: got %b want 000", k, out_onehot3); end
            if (out_err3 !== 1'b1) begin errors++; $display("FAIL sat_err[%0d]: got %b want 1", k, out_err3); end
            if (int'(err_cnt3) != want) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, err_cnt3, want); end
        end
        in_valid3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks += 2;
        if (err_cnt3 !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", err_cnt3); end
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL sat_drain: got %b want 0", out_valid3); end
    endtask

    task automatic test_reset_full();
        in_valid3  = 1'b1;
        in_idx3    = 2'd0;
        out_ready3 = 1'b0;
        tick(1'b1, 2'd1, 1'b0);
        tick(1'b1, 2'd2, 1'b0);
        in_valid3 = 1'b0;
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rf_full: got %b want 0", in_ready); end
        if (in_ready3 !== 1'b0) begin errors++; $display("FAIL rf_full3: got %b want 0", in_ready3); end
        if (err_cnt3 !== 8'd255) begin errors++; $display("FAIL rf_cnt_before: got %0d want 255", err_cnt3); end
        rst = 1'b1;
        tick(1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b want 0", out_valid); end
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL rf_valid3: got %b want 0", out_valid3); end
        if (err_cnt3 !== 8'd0) begin errors++; $display("FAIL rf_cnt: got %0d want 0", err_cnt3); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rf_in_ready: got %b want 0", in_ready); end
        if (out_onehot !== 4'd0) begin errors++; $display("FAIL rf_onehot: got %b want 0000", out_onehot); end
        out_ready3 = 1'b1;
        tick(1'b0, 2'd0, 1'b1);
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready_after: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_ghost: got %b want 0", out_valid); end
        tick(1'b0, 2'd0, 1'b1);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_ghost2: got %b want 0", out_valid); end
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL rf_ghost3: got %b want 0", out_valid3); end
    endtask

    task automatic test_random();
        logic       v, ordy;
        logic [1:0] idx;
        for (int i = 0; i < 600; i++) begin
            checks += 3;
            if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, mq.size() > 0); end
            if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, m_rdy); end
            if (err_cnt !== 8'd0) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want 0", i, err_cnt); end
            if (mq.size() > 0) begin
                checks += 2;
                if (out_onehot !== mq[0].oh) begin errors++; $display("FAIL rnd_onehot[%0d]: got %b want %b", i, out_onehot, mq[0].oh); end
                if (out_err !== mq[0].err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", i, out_err, mq[0].err); end
            end
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            idx  = 2'($urandom_range(0, 3));
            tick(v, idx, ordy);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b want 0", out_valid); end
    endtask

`ifdef ONEHOT_DEC_PARITY_EN
    task automatic test_parity();
        par_flip = 1'b1;
        tick(1'b1, 2'd1, 1'b1);
        par_flip = 1'b0;
        checks += 4;
        if (out_onehot !== 4'd0) begin errors++; $display("FAIL par_onehot: got %b want 0000", out_onehot); end
        if (out_par_err !== 1'b1) begin errors++; $display("FAIL par_flag: got %b want 1", out_par_err); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL par_err: got %b want 0", out_err); end
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL par_cnt: got %0d want 0", err_cnt); end
        tick(1'b1, 2'd1, 1'b1);
        checks += 2;
        if (out_onehot !== 4'b0010) begin errors++; $display("FAIL par_good_onehot: got %b want 0010", out_onehot); end
        if (out_par_err !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", out_par_err); end
        tick(1'b0, 2'd0, 1'b1);
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        par_flip   = 1'b0;
        m_rdy      = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_idx     = 2'd0;
        out_ready  = 1'b0;
        in_valid3  = 1'b0;
        in_idx3    = 2'd0;
        out_ready3 = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_saturate();
        test_reset_full();
        test_random();
`ifdef ONEHOT_DEC_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
